// File: rtl/clock_display_mux.sv
// clock_display_mux: scans HH:MM:SS onto a 6-digit multiplexed seven-segment display, PM on digit 0's dp.
// Optional `define CLOCK_DISPLAY_COLON_BLINK_EN lights dp on digits 2 and 4 on even seconds.
module clock_display_mux #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pm,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [5:0]  AN_OFF   = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  dig_q, dig_d;
  logic [7:0]  snap_hh_q, snap_hh_d;
  logic [7:0]  snap_mm_q, snap_mm_d;
  logic [7:0]  snap_ss_q, snap_ss_d;
  logic        snap_pm_q, snap_pm_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [5:0]  an_q, an_d;

  logic [3:0]  nib;
  logic [6:0]  seg_raw;
  logic        dp_raw;
  logic        colon;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    nib = 4'd0;
    case (dig_q)
      3'd0:    nib = snap_ss_q[3:0];
      3'd1:    nib = snap_ss_q[7:4];
      3'd2:    nib = snap_mm_q[3:0];
      3'd3:    nib = snap_mm_q[7:4];
      3'd4:    nib = snap_hh_q[3:0];
      3'd5:    nib = snap_hh_q[7:4];
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
`ifdef CLOCK_DISPLAY_COLON_BLINK_EN
    colon = ((dig_q == 3'd2) || (dig_q == 3'd4)) && !snap_ss_q[0];
`else
    colon = 1'b0;
`endif
    // Leading hour digit is blanked when zero but its anode still fires.
    seg_raw = ((dig_q == 3'd5) && (nib == 4'd0)) ? 7'h00 : decode(nib);
    dp_raw  = ((dig_q == 3'd0) && snap_pm_q) || colon;
  end

  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    dig_d     = dig_q;
    snap_hh_d = snap_hh_q;
    snap_mm_d = snap_mm_q;
    snap_ss_d = snap_ss_q;
    snap_pm_d = snap_pm_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = 16'd0;
      if (dig_q == 3'd5) begin
        dig_d     = 3'd0;
        snap_hh_d = hh;
        snap_mm_d = mm;
        snap_ss_d = ss;
        snap_pm_d = pm;
      end else begin
        dig_d = dig_q + 3'd1;
      end
    end

    // Slot start is blanked so the previous digit's segments never ghost onto the new anode.
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (cnt_q != 16'd0) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_raw  : dp_raw;
      an_d  = AN_ACTIVE_LOW ? ~(6'd1 << dig_q) : (6'd1 << dig_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 16'd0;
      dig_q     <= 3'd0;
      snap_hh_q <= 8'h12;
      snap_mm_q <= 8'h00;
      snap_ss_q <= 8'h00;
      snap_pm_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      an_q      <= AN_OFF;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      snap_hh_q <= snap_hh_d;
      snap_mm_q <= snap_mm_d;
      snap_ss_q <= snap_ss_d;
      snap_pm_q <= snap_pm_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench for clock_display_mux: active-high instance plus an inverted-polarity twin fed identically.
module tb_clock_display_mux;

`ifdef CLOCK_DISPLAY_COLON_BLINK_EN
  localparam logic COLON = 1'b1;
`else
  localparam logic COLON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pm;
  logic [7:0] hh, mm, ss;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [5:0] an0, an1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clock_display_mux #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .reset(reset), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .seg(seg0), .dp(dp0), .an(an0)
  );

  clock_display_mux #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .reset(reset), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .seg(seg1), .dp(dp1), .an(an1)
  );

  // Compares {an, seg, dp} of both instances; the expected vector is given in active-high form.
  task automatic chk(input string tag, input logic [5:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    logic [13:0] obs_hi, exp_hi, obs_lo, exp_lo;
    obs_hi = {an0, seg0, dp0};
    exp_hi = {e_an, e_seg, e_dp};
    obs_lo = {an1, seg1, dp1};
    exp_lo = ~exp_hi;
    n_cmp++;
    assert (obs_hi === exp_hi) else begin
      n_err++;
      $error("FAIL %s hi observed=%h expected=%h", tag, obs_hi, exp_hi);
    end
    n_cmp++;
    assert (obs_lo === exp_lo) else begin
      n_err++;
      $error("FAIL %s lo observed=%h expected=%h", tag, obs_lo, exp_lo);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One digit slot of SCAN_DIV=4 cycles: one blank cycle, then three lit cycles.
  task automatic slot(input string tag, input int d, input logic [6:0] s, input logic p);
    tick();
    chk({tag, "_blank"}, 6'h00, 7'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_lit"}, 6'd1 << d, s, p);
    end
  endtask

  initial begin
    reset = 1'b1;
    pm    = 1'b0;
    hh    = 8'h03;
    mm    = 8'h21;
    ss    = 8'h11;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", 6'h00, 7'h00, 1'b0);
    end
    reset = 1'b0;

    // Frame 1: reset snapshot 12:00:00 AM; inputs change mid-frame.
    slot("f1_d0", 0, 7'h3F, 1'b0);
    slot("f1_d1", 1, 7'h3F, 1'b0);
    slot("f1_d2", 2, 7'h3F, COLON);
    hh = 8'h09; mm = 8'h45; ss = 8'h37; pm = 1'b1;
    slot("f1_d3", 3, 7'h3F, 1'b0);
    slot("f1_d4", 4, 7'h5B, COLON);
    slot("f1_d5", 5, 7'h06, 1'b0);

    // Frame 2: 09:45:37 PM, leading hour zero blanked.
    slot("f2_d0", 0, 7'h07, 1'b1);
    hh = 8'h08; mm = 8'h5C; ss = 8'h36; pm = 1'b0;
    slot("f2_d1", 1, 7'h4F, 1'b0);
    slot("f2_d2", 2, 7'h6D, 1'b0);
    slot("f2_d3", 3, 7'h66, 1'b0);
    slot("f2_d4", 4, 7'h6F, 1'b0);
    slot("f2_d5", 5, 7'h00, 1'b0);

    // Frame 3: 08:5C:36 AM, invalid nibble shows dash, even second.
    slot("f3_d0", 0, 7'h7D, 1'b0);
    ss = 8'h37;
    slot("f3_d1", 1, 7'h4F, 1'b0);
    slot("f3_d2", 2, 7'h40, COLON);
    slot("f3_d3", 3, 7'h6D, 1'b0);
    slot("f3_d4", 4, 7'h7F, COLON);
    slot("f3_d5", 5, 7'h00, 1'b0);

    // Frame 4: odd second, colon off.
    slot("f4_d0", 0, 7'h07, 1'b0);
    slot("f4_d1", 1, 7'h4F, 1'b0);
    slot("f4_d2", 2, 7'h40, 1'b0);
    slot("f4_d3", 3, 7'h6D, 1'b0);
    slot("f4_d4", 4, 7'h7F, 1'b0);
    slot("f4_d5", 5, 7'h00, 1'b0);

    // Frame 5: reset asserted while digit 3 is being scanned.
    slot("f5_d0", 0, 7'h07, 1'b0);
    slot("f5_d1", 1, 7'h4F, 1'b0);
    slot("f5_d2", 2, 7'h40, 1'b0);
    tick();
    chk("f5_d3_blank", 6'h00, 7'h00, 1'b0);
    tick();
    chk("f5_d3_lit", 6'b001000, 7'h6D, 1'b0);
    reset = 1'b1;
    tick();
    chk("midscan_reset", 6'h00, 7'h00, 1'b0);
    reset = 1'b0;

    // Post-reset frame restarts from digit 0 with the 12:00:00 AM snapshot.
    slot("r_d0", 0, 7'h3F, 1'b0);
    slot("r_d1", 1, 7'h3F, 1'b0);
    slot("r_d2", 2, 7'h3F, COLON);
    slot("r_d3", 3, 7'h3F, 1'b0);
    slot("r_d4", 4, 7'h5B, COLON);
    slot("r_d5", 5, 7'h06, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_display_mux.md
Name: clock_display_mux

Overview:
- Downstream consumer of the 12-hour BCD clock's outputs: `hh`, `mm`, `ss` and `pm`.
- Drives a 6-digit, time-multiplexed seven-segment display (HH MM SS), with the PM indicator on a decimal point.
- Snapshots the time once per scan frame so a displayed frame never mixes values from before and after a clock tick.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit slot lasts; legal range 2..65535.
- SEG_ACTIVE_LOW, 1: 1 means `seg`/`dp` are driven low to light a segment; 0 means active-high.
- AN_ACTIVE_LOW, 1: 1 means the selected `an` bit is driven low; 0 means active-high.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pm  input  1  PM flag from the clock block
- hh  input  8  hours, BCD, 0x01..0x12
- mm  input  8  minutes, BCD, 0x00..0x59
- ss  input  8  seconds, BCD, 0x00..0x59
- seg  output  7  segment lines {g,f,e,d,c,b,a}, registered
- dp  output  1  decimal point, registered
- an  output  6  digit enables, one-hot, bit k selects digit k, registered

Behaviour:
- Clocking and reset:
  - One clock, `clk`.
  - Reset is synchronous and active-high: sampled only on the rising edge of `clk`.
- Reset values:
  - `cnt` = 0, `dig` = 0.
  - Snapshot = {hh 0x12, mm 0x00, ss 0x00, pm 0}.
  - `an` all inactive, `seg` all off, `dp` off (levels per polarity parameters).
- Prescaler and digit counter:
  - `cnt` counts 0..SCAN_DIV-1 and wraps to 0.
  - When `cnt` == SCAN_DIV-1, `dig` advances 0,1,2,3,4,5 and wraps back to 0.
- Digit map:
  - 0 = ss[3:0], 1 = ss[7:4]
  - 2 = mm[3:0], 3 = mm[7:4]
  - 4 = hh[3:0], 5 = hh[7:4]
- Frame snapshot:
  - On the edge where `dig` wraps 5->0, the snapshot registers capture `hh`/`mm`/`ss`/`pm`.
  - Inputs are ignored at every other edge.
  - Input changes mid-frame appear at the next frame boundary.
- Output pipeline: outputs are registered, one cycle behind the state. On each edge, outputs load from the pre-edge `cnt`/`dig`/snapshot:
  - If `cnt` == 0: blank (anti-ghosting; all `an` inactive, segments off).
  - Otherwise: `an` = one-hot(`dig`), `seg` = decode(selected nibble), `dp` per the rules below.
  - Each digit is therefore lit SCAN_DIV-1 of every SCAN_DIV cycles.
- Decode, active-high form, before polarity:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F
  - Nibbles 0xA..0xF decode to a dash, 0x40. Other digits are not altered.
- Leading-zero blank: digit 5 with nibble 0 drives `seg` all off, but its `an` is still asserted.
- PM indicator: `dp` is lit on digit 0 iff snapshot `pm` = 1.
- Polarity: `seg` and `dp` are inverted when SEG_ACTIVE_LOW = 1; `an` is inverted when AN_ACTIVE_LOW = 1.
- Reset mid-scan:
  - The next edge restores all reset values.
  - The first post-reset cycle with reset low sees `cnt` == 0, so outputs stay blank one more cycle.
  - Digit 0 is then shown from the reset snapshot (00 seconds) until the first frame boundary.
- Simultaneous events:
  - A clock tick at the same edge as a frame boundary is captured if the new value is present at that edge's inputs.
  - Otherwise the old value is captured; no partial capture is possible, since all fields load together.

Optional Feature:
- Macro: CLOCK_DISPLAY_COLON_BLINK_EN.
- Defined: `dp` on digits 2 and 4 (the HH:MM and MM:SS separators) lights when snapshot ss[0] == 0, blinking the colon at 0.5 Hz per second-parity. Digit 0's PM `dp` is unchanged.
- Undefined: `dp` is lit only on digit 0 for PM; digits 2 and 4 have `dp` always off.

Test Plan:
- Reset:
  - Stimulus: SCAN_DIV = 4, both polarities = 0; hold reset 3 cycles then release.
  - Response: outputs zero for the reset cycles plus one more; then `an` = 6'b000001 and `seg` = 0x3F for 3 cycles; then blank 1 cycle; then `an` = 6'b000010 and `seg` = 0x3F.
- Frame capture:
  - Stimulus: inputs hh = 0x09, mm = 0x45, ss = 0x37, pm = 1 applied mid-frame.
  - Response: the current frame still shows the 12:00:00 snapshot. After the 5->0 wrap, the digits show 7, 3, 5, 4, 9, then digit 5 blank (`seg` = 0, `an` bit5 = 1), with `dp` = 1 on digit 0 only.
- Invalid BCD:
  - Stimulus: mm = 0x5C.
  - Response: digit 2 shows `seg` = 0x40; digit 3 shows 0x6D.
- Polarity:
  - Stimulus: SEG_ACTIVE_LOW = 1, AN_ACTIVE_LOW = 1, digit value 8.
  - Response: `seg` = 7'h00 and the active `an` bit is 0, others 1. During blank slots `seg` = 7'h7F and `an` = 6'h3F.
- Reset mid-scan:
  - Stimulus: assert reset while `dig` = 3.
  - Response: next edge gives `cnt` = 0, `dig` = 0, blank outputs; the snapshot returns to 12:00:00 AM.
- Colon blink, with CLOCK_DISPLAY_COLON_BLINK_EN defined:
  - Stimulus: ss = 0x36, then 0x37 on the following frame.
  - Response: `dp` = 1 on digits 2 and 4 in the first frame and 0 in the second. With the macro undefined, `dp` on digits 2 and 4 is always 0.
